// File: rtl/cdr_pkg.sv
// Shared types for the clock-recovery phase controller: lock FSM states,
// phase-detector vote encoding and the phase-index width helper.
package cdr_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    UNLOCK  = 2'd2
  } cdr_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    EARLY = 2'd1,
    LATE  = 2'd2
  } cdr_vote_e;

  function automatic int phase_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdr_loop_filter.sv
// Saturating early/late vote accumulator; emits a one-cycle advance/retard
// request in the same cycle the threshold is hit and clears itself.
module cdr_loop_filter
  import cdr_pkg::*;
#(
  parameter  int FilterDepth = 8,
  localparam int AW          = $clog2(FilterDepth) + 2
) (
  input  logic      ref_clk,
  input  logic      rst_n,
  input  logic      bit_en,
  input  logic      hold,
  input  cdr_vote_e vote,
  output logic      adv,
  output logic      ret
);

  localparam logic signed [AW-1:0] ONE = AW'(1);
  localparam logic signed [AW-1:0] POS = AW'(FilterDepth);
  localparam logic signed [AW-1:0] NEG = -POS;

  logic signed [AW-1:0] acc, acc_upd;
  logic                 qual;

  assign qual = bit_en & ~hold;

  always_comb begin
    acc_upd = acc;
    if (qual) begin
      unique case (vote)
        LATE:    acc_upd = acc + ONE;
        EARLY:   acc_upd = acc - ONE;
        default: acc_upd = acc;
      endcase
    end
  end

  // acc only ever touches the threshold for the cycle it is compared
  assign adv = qual & (acc_upd == POS);
  assign ret = qual & (acc_upd == NEG);

  always_ff @(posedge ref_clk) begin
    if (!rst_n)          acc <= '0;
    else if (adv || ret) acc <= '0;
    else                 acc <= acc_upd;
  end

endmodule

// File: rtl/cdr_phase_ctrl.sv
// CDR phase-select controller: loop filter, wrapping phase register and lock FSM.
// Optional CDR_SLIP_STATS_EN adds a saturating 16-bit phase-step counter port.
module cdr_phase_ctrl
  import cdr_pkg::*;
#(
  parameter int NumPhase    = 5,
  parameter int FilterDepth = 8,
  parameter int LockCount   = 16,
  parameter int UnlockSlips = 4
) (
  input  logic                         ref_clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  input  logic                         transition,
  input  logic                         early,
  input  logic                         late,
  input  logic                         hold,
  output logic [phase_w(NumPhase)-1:0] phase_sel,
  output logic [NumPhase-1:0]          phase_sel_oh,
  output logic                         phase_step,
  output logic                         locked,
  output cdr_state_e                   state
`ifdef CDR_SLIP_STATS_EN
  ,
  output logic [15:0]                  slip_count
`endif
);

  localparam int PW = phase_w(NumPhase);
  localparam int CW = $clog2(LockCount + 1);
  localparam int SW = $clog2(UnlockSlips + 1);

  cdr_vote_e      vote;
  cdr_state_e     state_n;
  logic           adv, ret, step, bit_qual;
  logic [CW-1:0]  quiet_cnt, quiet_n, win_cnt, win_n;
  logic [SW-1:0]  slip_cnt, slip_n;

  assign vote     = (late & ~early) ? LATE : (early & ~late) ? EARLY : NONE;
  assign bit_qual = sample_valid & transition & ~hold;
  assign step     = adv | ret;

  cdr_loop_filter #(.FilterDepth(FilterDepth)) u_filt (
    .ref_clk (ref_clk),
    .rst_n   (rst_n),
    .bit_en  (sample_valid & transition),
    .hold    (hold),
    .vote    (vote),
    .adv     (adv),
    .ret     (ret)
  );

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      phase_sel  <= '0;
      phase_step <= 1'b0;
    end else begin
      phase_step <= step;
      if (adv)
        phase_sel <= (phase_sel == PW'(NumPhase - 1)) ? '0 : phase_sel + PW'(1);
      else if (ret)
        phase_sel <= (phase_sel == '0) ? PW'(NumPhase - 1) : phase_sel - PW'(1);
    end
  end

  for (genvar i = 0; i < NumPhase; i++) begin : g_oh
    assign phase_sel_oh[i] = (phase_sel == PW'(i));
  end

  // hold freezes the whole FSM, including the UNLOCK -> ACQUIRE hop
  always_comb begin
    state_n = state;
    quiet_n = quiet_cnt;
    win_n   = win_cnt;
    slip_n  = slip_cnt;
    if (!hold) begin
      unique case (state)
        ACQUIRE: if (bit_qual) begin
          if (step) quiet_n = '0;
          else if (quiet_cnt == CW'(LockCount - 1)) begin
            quiet_n = '0;
            state_n = LOCKED;
          end else quiet_n = quiet_cnt + CW'(1);
        end
        LOCKED: if (bit_qual) begin
          // a step on the wrap bit belongs to the new window
          if (win_cnt == CW'(LockCount - 1)) begin
            win_n  = '0;
            slip_n = SW'(step);
          end else begin
            win_n  = win_cnt + CW'(1);
            slip_n = slip_cnt + SW'(step);
          end
          if (slip_n == SW'(UnlockSlips)) state_n = UNLOCK;
        end
        UNLOCK: begin
          state_n = ACQUIRE;
          quiet_n = '0;
          win_n   = '0;
          slip_n  = '0;
        end
        default: state_n = ACQUIRE;
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state     <= ACQUIRE;
      locked    <= 1'b0;
      quiet_cnt <= '0;
      win_cnt   <= '0;
      slip_cnt  <= '0;
    end else begin
      state     <= state_n;
      locked    <= (state_n == LOCKED);
      quiet_cnt <= quiet_n;
      win_cnt   <= win_n;
      slip_cnt  <= slip_n;
    end
  end

`ifdef CDR_SLIP_STATS_EN
  always_ff @(posedge ref_clk) begin
    if (!rst_n)                            slip_count <= '0;
    else if (step && slip_count != 16'hFFFF) slip_count <= slip_count + 16'd1;
  end
`endif

endmodule
